// File: rtl/risc_pkg.sv
// Shared decode constants: opcodes, ALU op encodings, instruction field positions.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package risc_pkg;

  // Opcodes understood by the decode stage
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Instruction field positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 2;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Control half of the bundle handed to the ALU
  typedef struct packed {
    logic [2:0] alu;
    logic [4:0] rd;
    logic       we;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/regfile_32x32.sv
// Register file: two async read ports, one sync write port, r0 reads zero.
// Latency: reads combinational, write visible the cycle after the write edge.
// Backpressure: none; writes are always accepted.
module regfile_32x32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [4:0]        ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              we,
  input  logic [4:0]        wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] mem_q [32];
  logic [DATA_W-1:0] mem_d [32];

  // Next-state of the array: one entry updated per write, r0 never written
  always_comb begin
    mem_d = mem_q;
    if (we && (wa != 5'd0)) begin
      mem_d[wa] = wd;
    end
  end

  // Array storage, cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read ports; r0 is hardwired to zero
  always_comb begin
    rd0 = (ra0 == 5'd0) ? '0 : mem_q[ra0];
    rd1 = (ra1 == 5'd0) ? '0 : mem_q[ra1];
  end

endmodule

// File: rtl/decode_stage.sv
// Decode + operand fetch for R-type/ADDI with write-through bypass and RAW scoreboard.
// Latency: 1 cycle from accepted instruction to out_valid.
// Backpressure: in_ready drops on RAW hazard or when a held bundle is not consumed.
module decode_stage
  import risc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_instr,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_alu_control,
  output logic [4:0]        out_rd,
  output logic              out_we,
  output logic              out_illegal,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd, dest;
  logic [2:0]        funct;
  logic [15:0]       imm;
  logic              is_r, is_addi, is_illegal, we_dec;
  logic [DATA_W-1:0] rf_a, rf_b, opnd_a, opnd_b;
  logic [NREGS-1:0]  wb_clr, pend_eff;
  logic              stall, transfer;
  logic              unused_bits;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  ctrl_t             out_ctrl_q, out_ctrl_d;
  logic [NREGS-1:0]  pending_q, pending_d;

  assign unused_bits = ^in_instr[10:3];

  regfile_32x32 #(.DATA_W(DATA_W)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra0   (rs),
    .rd0   (rf_a),
    .ra1   (rt),
    .rd1   (rf_b),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  // Field extraction and opcode classification
  always_comb begin
    opcode     = in_instr[OPC_HI:OPC_LO];
    rs         = in_instr[RS_HI:RS_LO];
    rt         = in_instr[RT_HI:RT_LO];
    rd         = in_instr[RD_HI:RD_LO];
    funct      = in_instr[FN_HI:FN_LO];
    imm        = in_instr[IMM_HI:IMM_LO];
    is_r       = (opcode == OP_RTYPE);
    is_addi    = (opcode == OP_ADDI);
    is_illegal = !is_r && !is_addi;
    dest       = is_r ? rd : rt;
    we_dec     = !is_illegal && (dest != 5'd0);
  end

  // Operand select: a writeback landing this cycle bypasses the stale array value
  always_comb begin
    opnd_a = (wb_en && (wb_addr == rs) && (rs != 5'd0)) ? wb_data : rf_a;
    opnd_b = (wb_en && (wb_addr == rt) && (rt != 5'd0)) ? wb_data : rf_b;
  end

  // Hazard detection against pending writes, ignoring those retiring right now
  always_comb begin
    wb_clr   = wb_en ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_addr) : '0;
    pend_eff = pending_q & ~wb_clr;
    stall    = in_valid && (pend_eff[rs] || (is_r && pend_eff[rt]));
    in_ready = !stall && (!out_valid_q || out_ready);
    transfer = in_valid && in_ready;
  end

  // Scoreboard update: a new set wins over a same-cycle retire of that register
  always_comb begin
    pending_d = pend_eff;
    if (transfer && we_dec) begin
      pending_d[dest] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Output bundle: load on transfer, hold under backpressure, drop valid on consume
  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_ctrl_d  = out_ctrl_q;
    if (transfer) begin
      out_valid_d = 1'b1;
      if (is_illegal) begin
        out_a_d    = '0;
        out_b_d    = '0;
        out_ctrl_d = '{alu: 3'b000, rd: 5'd0, we: 1'b0, illegal: 1'b1};
      end else begin
        out_a_d    = opnd_a;
        out_b_d    = is_r ? opnd_b : {{(DATA_W-16){imm[15]}}, imm};
        out_ctrl_d = '{alu: (is_r ? funct : ALU_ADD), rd: dest, we: we_dec, illegal: 1'b0};
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_ctrl_q  <= '0;
      pending_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_ctrl_q  <= out_ctrl_d;
      pending_q   <= pending_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_a           = out_a_q;
  assign out_b           = out_b_q;
  assign out_alu_control = out_ctrl_q.alu;
  assign out_rd          = out_ctrl_q.rd;
  assign out_we          = out_ctrl_q.we;
  assign out_illegal     = out_ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a queue-based scoreboard and output monitor.
// Latency: n/a.
// Backpressure: driven directly from the stimulus sequence.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_alu_control;
  logic [4:0]  out_rd;
  logic        out_we, out_illegal;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   waited;

  decode_stage #(.DATA_W(32), .NREGS(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_instr        (in_instr),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_a           (out_a),
    .out_b           (out_b),
    .out_alu_control (out_alu_control),
    .out_rd          (out_rd),
    .out_we          (out_we),
    .out_illegal     (out_illegal),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [2:0] fn);
    return {6'h00, rs, rt, rd, 8'h00, fn};
  endfunction

  function automatic logic [31:0] addi(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
    return {6'h08, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] alu,
                              input logic [4:0] rd, input logic we, input logic ill);
    exp_t e;
    e.a = a; e.b = b; e.alu = alu; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Present an instruction, wait (bounded) for acceptance, push its expected bundle.
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input string nm, input logic [31:0] instr, input exp_t e,
                       output int nwait);
    in_valid = 1'b1;
    in_instr = instr;
    nwait = 0;
    @(negedge clk);
    while (!in_ready && nwait < 20) begin
      nwait++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk({nm, "_accept_timeout"}, 32'(in_ready), 32'd1);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_latency"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wback(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  // Monitor: whenever the ALU consumes a bundle, compare it with the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_a", out_a, e.a);
        chk("mon_b", out_b, e.b);
        chk("mon_alu", 32'(out_alu_control), 32'(e.alu));
        chk("mon_rd", 32'(out_rd), 32'(e.rd));
        chk("mon_we", 32'(out_we), 32'(e.we));
        chk("mon_illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_ctrl", {24'd0, out_alu_control, out_rd}, 32'd0);
    chk("rst_flags", {30'd0, out_we, out_illegal}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // ADDI r1,r0,-5
    issue("addi_r1", addi(5'd0, 5'd1, 16'hFFFB), mk(32'd0, 32'hFFFF_FFFB, 3'b000, 5'd1, 1'b1, 1'b0), waited);
    chk("addi_r1_nowait", 32'(waited), 32'd0);

    // SUB r3=r1-r2 stalls on pending r1 until writeback of 7, which bypasses into A
    in_valid = 1'b1;
    in_instr = rtype(5'd1, 5'd2, 5'd3, 3'b001);
    repeat (2) begin
      @(negedge clk);
      chk("raw_stall", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd7;
    @(negedge clk);
    chk("raw_release", 32'(in_ready), 32'd1);
    exp_q.push_back(mk(32'd7, 32'd0, 3'b001, 5'd3, 1'b1, 1'b0));
    @(posedge clk); #1;
    wb_en = 1'b0;
    in_valid = 1'b0;
    chk("sub_latency", 32'(out_valid), 32'd1);

    // Retire r3, write r4, then read r4/r0 from the array
    wback(5'd3, 32'h55);
    wback(5'd4, 32'h1234);
    issue("rd_r4", rtype(5'd4, 5'd0, 5'd5, 3'b000), mk(32'h1234, 32'd0, 3'b000, 5'd5, 1'b1, 1'b0), waited);
    chk("rd_r4_nowait", 32'(waited), 32'd0);

    // Backpressure: ADDI r6,r4,1 held three cycles while the illegal op waits
    issue("addi_r6", addi(5'd4, 5'd6, 16'h0001), mk(32'h1234, 32'd1, 3'b000, 5'd6, 1'b1, 1'b0), waited);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hFC00_0000;
    repeat (3) begin
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_a", out_a, 32'h1234);
      chk("hold_b", out_b, 32'd1);
      chk("hold_rd", 32'(out_rd), 32'd6);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(mk(32'd0, 32'd0, 3'b000, 5'd0, 1'b0, 1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;

    // No stall after the illegal op; dest r0 suppresses write enable
    issue("addi_r7", addi(5'd0, 5'd7, 16'h0003), mk(32'd0, 32'd3, 3'b000, 5'd7, 1'b1, 1'b0), waited);
    chk("after_illegal_nowait", 32'(waited), 32'd0);
    issue("addi_r0", addi(5'd1, 5'd0, 16'h8000), mk(32'd7, 32'hFFFF_8000, 3'b000, 5'd0, 1'b0, 1'b0), waited);
    chk("addi_r0_nowait", 32'(waited), 32'd0);

    // Reset with a held bundle and r5 still pending
    issue("addi_r8", addi(5'd0, 5'd8, 16'h0002), mk(32'd0, 32'd2, 3'b000, 5'd8, 1'b1, 1'b0), waited);
    out_ready = 1'b0;
    @(negedge clk);
    chk("prerst_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_we", 32'(out_we), 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    issue("rd_r5_r4", rtype(5'd5, 5'd4, 5'd9, 3'b111), mk(32'd0, 32'd0, 3'b111, 5'd9, 1'b1, 1'b0), waited);
    chk("after_rst_nowait", 32'(waited), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand-fetch stage, directly upstream of the ALU. Accepts 32-bit instructions from fetch over a valid/ready handshake, decodes R-type and ADDI formats, and reads two operands from a 32-entry register file. It emits a registered operand/control bundle to the ALU and tracks pending writes with a scoreboard, stalling read-after-write hazards until the writeback port retires them.

## Interface
- DATA_W, 32, operand and register width
- NREGS, 32, register count (address width = 5, fixed)
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  fetch presents an instruction
- in_instr  in  32  instruction word
- in_ready  out  1  stage accepts in_instr this cycle
- out_valid  out  1  bundle valid to ALU
- out_ready  in  1  ALU consumes bundle
- out_a  out  DATA_W  operand A (rs value)
- out_b  out  DATA_W  operand B (rt value or sign-extended imm)
- out_alu_control  out  3  ALU op encoding
- out_rd  out  5  destination register
- out_we  out  1  result must be written back
- out_illegal  out  1  unsupported opcode
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback register
- wb_data  in  DATA_W  writeback value

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [2:0], imm [15:0].
- opcode 6'h00 (R-type): a=R[rs], b=R[rt], alu_control=funct, dest=rd, we=1.
- opcode 6'h08 (ADDI): a=R[rs], b=sign-extend(imm) to DATA_W, alu_control=3'b000, dest=rt, we=1.
- Any other opcode: bundle issued with out_illegal=1, out_we=0, a=b=0, alu_control=0, rd=0; no scoreboard update.
- dest=0 forces out_we=0 (r0 writes discarded).
- Register file: R0 reads 0 always; wb_en with wb_addr≠0 writes on clk edge.
- Write-through bypass: if wb_en and wb_addr==rs (or rt), nonzero, same cycle as decode, operand takes wb_data.
- Scoreboard: pending[31:1]. Set pending[dest] when an instruction with we=1 is accepted; clear pending[wb_addr] on wb_en. Same-cycle set and clear of the same register: set wins.
- Hazard: stall = in_valid and (pending[rs] or (R-type and pending[rt])), excluding registers cleared by wb_en this cycle. pending[0] is constant 0.
- Handshake: in_ready = !stall && (!out_valid || out_ready). Transfer when in_valid && in_ready. Output bundle held stable while out_valid && !out_ready.
- out_valid: set on transfer; cleared when out_ready and no new transfer.

## Timing
- Reset values: out_valid=0, in_ready reflects combinational equation (1 when in_valid=0), out_a=out_b=0, out_alu_control=0, out_rd=0, out_we=0, out_illegal=0, all registers 0, pending all 0.
- Latency: 1 cycle from accepted instruction to out_valid.
- Throughput: 1 instruction/cycle with no hazards and out_ready=1.
- in_ready combinational from in_valid, in_instr, pending, wb_*, out_valid, out_ready; no comb path from in_valid to out_valid.
- Reset mid-operation: bundle dropped, scoreboard cleared, register contents zeroed.
- Writeback to a register with no pending bit is legal; it updates the register only.

## Structure
- Shared package risc_pkg: opcode constants (OP_RTYPE=6'h00, OP_ADDI=6'h08), ALU op encodings (ADD 000 … SLT 111), field-position localparams.
- One sub-module: regfile_32x32 (two async read ports, one sync write port, r0 hardwired zero, reset-clear). Bypass and scoreboard stay in decode_stage.

## Test plan
- Reset, then ADDI r1,r0,-5 (imm 16'hFFFB) -> next cycle out_valid=1, out_a=0, out_b=32'hFFFF_FFFB, alu_control=000, out_rd=1, out_we=1.
- R-type r3=r1 SUB r2 (funct 001) issued right after ADDI r1 with no writeback -> in_ready=0 while pending[1]; wb_en r1=7 -> same cycle in_ready=1, out_a=7 via bypass.
- Write r4=32'h1234 via wb, then R-type rs=r4,rt=r0 -> out_a=32'h1234, out_b=0.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> bundle stable, in_ready=0; release -> next instruction accepted same cycle.
- Opcode 6'h3F -> out_illegal=1, out_we=0, no stall on following instructions.
- Assert reset with out_valid=1 and pending[5]=1 -> out_valid=0, pending clear, subsequent read of r5 returns 0 without stall.
